// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci job dispatcher.
// The tag width is a dispatcher parameter, so the tag travels beside job_t.
package fib_pkg;

  localparam int unsigned N_W    = 6;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [N_W-1:0]    n;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } job_t;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StBusy,
    StHold
  } state_e;

endpackage

// File: rtl/fib_job_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry one extra wrap bit.
module fib_job_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fib_job_dispatcher.sv
// Queues (n, a, b, tag) jobs and runs them one at a time on the shared Fibonacci
// core, aborting any run that exceeds TIMEOUT cycles, and returns tagged results.
module fib_job_dispatcher
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [N_W-1:0]    job_n_i,
  input  logic [DATA_W-1:0] job_a_i,
  input  logic [DATA_W-1:0] job_b_i,
  input  logic [TAG_W-1:0]  job_tag_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [TAG_W-1:0]  res_tag_o,
  output logic              res_timeout_o,
  output logic              core_r_enable_o,
  output logic [N_W-1:0]    core_init_n_o,
  output logic [DATA_W-1:0] core_init_a_o,
  output logic [DATA_W-1:0] core_init_b_o,
  input  logic              core_w_enable_i,
  input  logic [DATA_W-1:0] core_result_i,
  output logic              busy_o,
  output logic [15:0]       jobs_done_o
);

  localparam int unsigned FifoW = $bits(job_t) + TAG_W;
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  job_t              in_job, head_job, init_q;
  logic [TAG_W-1:0]  head_tag, tag_q;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              core_r_enable_q;
  logic              res_valid_q, res_timeout_q;
  logic [DATA_W-1:0] res_data_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic [15:0]       jobs_done_q;

  assign in_job.n  = job_n_i;
  assign in_job.a  = job_a_i;
  assign in_job.b  = job_b_i;

  assign job_ready_o = !fifo_full;
  assign fifo_push   = job_valid_i && job_ready_o;
  assign fifo_pop    = (state_q == StIdle) && !fifo_empty;

  fib_job_fifo #(
    .Depth (DEPTH),
    .Width (FifoW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i ({job_tag_i, in_job}),
    .pop_i   (fifo_pop),
    .rdata_o ({head_tag, head_job}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      init_q          <= '0;
      tag_q           <= '0;
      cnt_q           <= '0;
      core_r_enable_q <= 1'b0;
      res_valid_q     <= 1'b0;
      res_timeout_q   <= 1'b0;
      res_data_q      <= '0;
      res_tag_q       <= '0;
      jobs_done_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            init_q          <= head_job;
            tag_q           <= head_tag;
            core_r_enable_q <= 1'b1;
            state_q         <= StLaunch;
          end
        end
        // The core clears its done flag at this edge, so w_enable is not looked at here.
        StLaunch: begin
          core_r_enable_q <= 1'b0;
          cnt_q           <= '0;
          state_q         <= StBusy;
        end
        StBusy: begin
          cnt_q <= cnt_q + 1'b1;
          if (core_w_enable_i) begin
            res_data_q    <= core_result_i;
            res_tag_q     <= tag_q;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= StHold;
          end else if (cnt_q == TimeoutLast) begin
            res_data_q    <= '0;
            res_tag_q     <= tag_q;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= StHold;
          end
        end
        StHold: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            if (!res_timeout_q) jobs_done_q <= jobs_done_q + 16'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_r_enable_o = core_r_enable_q;
  assign core_init_n_o   = init_q.n;
  assign core_init_a_o   = init_q.a;
  assign core_init_b_o   = init_q.b;
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_tag_o       = res_tag_q;
  assign res_timeout_o   = res_timeout_q;
  assign busy_o          = (state_q != StIdle) || !fifo_empty;
  assign jobs_done_o     = jobs_done_q;

endmodule

// File: tb/tb_fib_job_dispatcher.sv
// Bench for fib_job_dispatcher: a timed Fibonacci core model drives the core side, and a
// job-level scoreboard predicts launches, latencies and results from the documented rules.
module tb_fib_job_dispatcher;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 60;
  localparam int unsigned CNT_W   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        job_valid = 1'b0, job_ready;
  logic [5:0]  job_n = '0;
  logic [31:0] job_a = '0, job_b = '0;
  logic [3:0]  job_tag = '0;
  logic        res_valid, res_ready = 1'b1;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        res_timeout;
  logic        core_r_enable;
  logic [5:0]  core_init_n;
  logic [31:0] core_init_a, core_init_b;
  logic        core_wen = 1'b0;
  logic [31:0] core_res = '0;
  logic        busy;
  logic [15:0] jobs_done;

  always #5 clk = ~clk;

  fib_job_dispatcher #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .job_valid_i     (job_valid),
    .job_ready_o     (job_ready),
    .job_n_i         (job_n),
    .job_a_i         (job_a),
    .job_b_i         (job_b),
    .job_tag_i       (job_tag),
    .res_valid_o     (res_valid),
    .res_ready_i     (res_ready),
    .res_data_o      (res_data),
    .res_tag_o       (res_tag),
    .res_timeout_o   (res_timeout),
    .core_r_enable_o (core_r_enable),
    .core_init_n_o   (core_init_n),
    .core_init_a_o   (core_init_a),
    .core_init_b_o   (core_init_b),
    .core_w_enable_i (core_wen),
    .core_result_i   (core_res),
    .busy_o          (busy),
    .jobs_done_o     (jobs_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fib(input int n, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      y = x;
      x = t;
    end
    return x;
  endfunction

  function automatic int run_cycles(input int n);
    int c;
    c = 5 + 5 * n;
    return (c < int'(TIMEOUT)) ? c : int'(TIMEOUT);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Core model (no reset): w_enable rises 4+5n edges after the sampling edge, result
  // is noise until then.
  int          core_cnt = 0;
  logic [31:0] core_fib = '0;
  always @(posedge clk) begin
    if (core_r_enable) begin
      core_cnt <= 4 + 5 * int'(core_init_n);
      core_wen <= 1'b0;
      core_fib <= fib(int'(core_init_n), core_init_a, core_init_b);
      core_res <= $urandom;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_wen <= 1'b1;
        core_res <= core_fib;
      end else begin
        core_res <= $urandom;
      end
    end
  end

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    int          push_edge;
  } job_rec_t;

  job_rec_t    pend[$];
  job_rec_t    cur;
  bit          inflight = 0;
  int          launch_edge = 0;
  int          jobs_model = 0;
  logic [31:0] res_log[$];

  // Scoreboard: sampled on the falling edge; events seen here take effect at the next edge.
  initial begin
    bit          prev_ren, prev_rv, prev_hold, exp_to;
    logic [31:0] hold_data, exp_data;
    logic [3:0]  hold_tag;
    logic        hold_to;
    prev_ren = 0; prev_rv = 0; prev_hold = 0;
    hold_data = '0; hold_tag = '0; hold_to = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        inflight = 0;
        jobs_model = 0;
        prev_ren = 0; prev_rv = 0; prev_hold = 0;
      end else begin
        if (core_r_enable) begin
          chk("r_enable_single_cycle", {31'b0, prev_ren}, 0);
          if (!prev_ren) begin
            chk("launch_while_idle", {31'b0, inflight}, 0);
            chk("launch_has_job", {31'b0, pend.size() != 0}, 1);
            if (pend.size() != 0) begin
              cur = pend.pop_front();
              chk("launch_n", {26'b0, core_init_n}, cur.n);
              chk("launch_a", core_init_a, cur.a);
              chk("launch_b", core_init_b, cur.b);
              chk("launch_no_bypass", {31'b0, cyc > cur.push_edge}, 1);
              inflight = 1;
              launch_edge = cyc + 1;
            end
          end
        end
        if (res_valid && !prev_rv) begin
          chk("result_expected", {31'b0, inflight}, 1);
          if (inflight) chk("result_latency", cyc, launch_edge + run_cycles(cur.n));
        end
        if (prev_hold) begin
          chk("hold_valid", {31'b0, res_valid}, 1);
          chk("hold_data", res_data, hold_data);
          chk("hold_tag", {28'b0, res_tag}, hold_tag);
          chk("hold_timeout", {31'b0, res_timeout}, hold_to);
        end
        chk("job_ready", {31'b0, job_ready}, pend.size() < DEPTH);
        chk("busy", {31'b0, busy}, (pend.size() != 0) || inflight);
        chk("jobs_done", {16'b0, jobs_done}, jobs_model);
        if (res_valid && res_ready && inflight) begin
          exp_to   = (5 + 5 * cur.n) > int'(TIMEOUT);
          exp_data = exp_to ? 32'd0 : fib(cur.n, cur.a, cur.b);
          chk("res_data", res_data, exp_data);
          chk("res_tag", {28'b0, res_tag}, cur.tag);
          chk("res_timeout", {31'b0, res_timeout}, exp_to);
          res_log.push_back(res_data);
          if (!exp_to) jobs_model++;
          inflight = 0;
        end
        if (job_valid && job_ready)
          pend.push_back('{int'(job_n), job_a, job_b, job_tag, cyc + 1});
        prev_ren  = core_r_enable;
        prev_rv   = res_valid;
        prev_hold = res_valid && !res_ready;
        hold_data = res_data;
        hold_tag  = res_tag;
        hold_to   = res_timeout;
      end
    end
  end

  // Callers are aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic push_job(input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
    bit got;
    got = 0;
    job_valid = 1'b1;
    job_n = 6'(n);
    job_a = a;
    job_b = b;
    job_tag = tag;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (job_ready) begin
        got = 1;
        break;
      end
    end
    chk("push_accepted", {31'b0, got}, 1);
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  // Returns at the falling edge where res_valid is first seen high.
  task automatic wait_res();
    bit got;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1;
        break;
      end
    end
    chk("result_arrived", {31'b0, got}, 1);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, seen, base;
    bit ok, push_done;

    #2 rst = 1'b1;
    #1;
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_job_ready", {31'b0, job_ready}, 1);
    chk("rst_r_enable", {31'b0, core_r_enable}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_jobs_done", {16'b0, jobs_done}, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_init_a", core_init_a, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    realign();

    // Minimum-latency single job.
    res_ready = 1'b1;
    push_job(0, 32'd7, 32'd3, 4'd2);
    k = cyc;
    wait_res();
    chk("single_latency", cyc - k, 7);
    chk("single_data", res_data, 7);
    chk("single_tag", {28'b0, res_tag}, 2);
    chk("single_timeout", {31'b0, res_timeout}, 0);
    realign();
    @(negedge clk);
    chk("single_jobs_done", {16'b0, jobs_done}, 1);
    realign();

    // Long run, the exact-timeout boundary (completion wins), an abort, then recovery.
    push_job(10, 32'd1, 32'd0, 4'd5);
    wait_res();
    chk("n10_data", res_data, 89);
    realign();
    push_job(11, 32'd1, 32'd0, 4'd6);
    wait_res();
    chk("n11_data", res_data, 144);
    chk("n11_timeout", {31'b0, res_timeout}, 0);
    realign();
    push_job(12, 32'd1, 32'd0, 4'd7);
    wait_res();
    chk("n12_data", res_data, 0);
    chk("n12_timeout", {31'b0, res_timeout}, 1);
    chk("n12_tag", {28'b0, res_tag}, 7);
    realign();
    push_job(2, 32'd1, 32'd0, 4'd8);
    wait_res();
    chk("after_to_data", res_data, 2);
    realign();
    @(negedge clk);
    chk("after_to_jobs_done", {16'b0, jobs_done}, 4);
    realign();

    // Back-to-back burst overflowing the FIFO.
    base = res_log.size();
    for (int i = 1; i <= 5; i++) push_job(i, 32'd1, 32'd0, 4'(i));
    @(negedge clk);
    chk("burst_fifo_full", {31'b0, job_ready}, 0);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (res_log.size() >= base + 5) begin
        ok = 1;
        break;
      end
    end
    chk("burst_done", {31'b0, ok}, 1);
    if (ok) begin
      chk("burst_r0", res_log[base], 1);
      chk("burst_r1", res_log[base+1], 2);
      chk("burst_r2", res_log[base+2], 3);
      chk("burst_r3", res_log[base+3], 5);
      chk("burst_r4", res_log[base+4], 8);
    end
    realign();
    @(negedge clk);
    chk("burst_jobs_done", {16'b0, jobs_done}, 9);
    realign();

    // Backpressure: result held 20 cycles, queued job launches right after the handshake.
    res_ready = 1'b0;
    push_job(0, 32'd4, 32'd4, 4'd9);
    push_job(1, 32'd2, 32'd2, 4'd10);
    wait_res();
    repeat (20) @(negedge clk);
    chk("hold_no_launch", {31'b0, core_r_enable}, 0);
    realign();
    res_ready = 1'b1;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (core_r_enable) begin
        seen = i;
        break;
      end
    end
    chk("relaunch_delay", seen, 3);
    wait_res();
    chk("hold_second_data", res_data, 4);
    realign();

    // Asynchronous reset in the middle of a run.
    push_job(9, 32'd1, 32'd0, 4'd3);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (core_r_enable) begin
        ok = 1;
        break;
      end
    end
    chk("mid_rst_launch_seen", {31'b0, ok}, 1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_res_valid", {31'b0, res_valid}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_r_enable", {31'b0, core_r_enable}, 0);
    chk("mid_rst_init_n", {26'b0, core_init_n}, 0);
    chk("mid_rst_jobs_done", {16'b0, jobs_done}, 0);
    chk("mid_rst_job_ready", {31'b0, job_ready}, 1);
    realign();
    rst = 1'b0;
    repeat (60) realign();
    chk("stale_no_result", {31'b0, res_valid}, 0);
    push_job(3, 32'd1, 32'd0, 4'd4);
    wait_res();
    chk("post_rst_data", res_data, 3);
    realign();
    @(negedge clk);
    chk("post_rst_jobs_done", {16'b0, jobs_done}, 1);
    realign();

    // Randomised traffic with random consumer backpressure.
    push_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) realign();
          push_job(int'($urandom_range(0, 13)), $urandom, $urandom, 4'($urandom_range(0, 15)));
        end
        push_done = 1;
      end
      begin
        while (!push_done) begin
          realign();
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    res_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (pend.size() == 0 && !inflight) begin
        ok = 1;
        break;
      end
    end
    chk("random_drained", {31'b0, ok}, 1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
